// File: rtl/rom_stream_reader.sv
// rom_stream_reader: drives a combinational ROM address, captures the read
// word and streams a programmed burst over a valid/ready interface.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   start               burst request, sampled only in IDLE
//   start_addr, length  first ROM word and word count of the burst (0..N)
//   busy                high while a burst is fetching or draining
//   done                one-cycle pulse after the last word is accepted
//   err                 one-cycle pulse when a start is rejected
//   rom_addr, rom_data  registered ROM address / combinational read data
//   out_data, out_valid, out_ready  streamed word with handshake
//   checksum            XOR of the burst's words (ROM_STREAM_CHECKSUM_EN only)
//
// Optional feature macro: ROM_STREAM_CHECKSUM_EN.

module rom_stream_reader #(
    parameter  int N  = 64,
    localparam int AW = $clog2(N),
    localparam int LW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [LW-1:0] length,
    output logic          busy,
    output logic          done,
    output logic          err,
`ifdef ROM_STREAM_CHECKSUM_EN
    output logic [31:0]   checksum,
`endif
    output logic [AW-1:0] rom_addr,
    input  logic [31:0]   rom_data,
    output logic [31:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [LW-1:0] DEPTH    = LW'(N);
    localparam logic [AW-1:0] LAST_ADR = AW'(N - 1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [31:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
`ifdef ROM_STREAM_CHECKSUM_EN
    logic [31:0]   csum_q, csum_d;
`endif

    logic args_bad;
    logic capture;

    // Zero-extend the address so the range check also works for
    // non-power-of-two depths.
    assign args_bad = ({1'b0, start_addr} >= DEPTH) || (length > DEPTH);

    // A new word may be loaded whenever the output register is empty or
    // is being emptied this same edge.
    assign capture = (state_q == FETCH) && (!valid_q || out_ready);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef ROM_STREAM_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (args_bad) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d = start_addr;
                        rem_d  = length;
`ifdef ROM_STREAM_CHECKSUM_EN
                        csum_d = '0;
`endif
                        if (length == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
            end
            FETCH: begin
                if (capture) begin
                    data_d  = rom_data;
                    valid_d = 1'b1;
                    addr_d  = (addr_q == LAST_ADR) ? '0 : addr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
`ifdef ROM_STREAM_CHECKSUM_EN
                    csum_d  = csum_q ^ rom_data;
`endif
                    if (rem_q == LW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ROM_STREAM_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef ROM_STREAM_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign rom_addr  = addr_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
`ifdef ROM_STREAM_CHECKSUM_EN
    assign checksum  = csum_q;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: vector table, hand sequences and random bursts
// checked against a ROM-index reference model.

module tb_rom_stream_reader;

    localparam int N  = 64;
    localparam int AW = 6;
    localparam int LW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
`ifdef ROM_STREAM_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    logic [31:0] rom_mem [N];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_mem[rom_addr];

    rom_stream_reader #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .err        (err),
`ifdef ROM_STREAM_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    typedef struct {
        int sa;
        int len;
        int mode;
        bit poke;
        bit exp_err;
        int exp_end;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // mode 0: always ready, 1: pattern 1,0,0,1,0,1, 2: random
    task automatic run_burst(input string name, input int sa, input int len,
                             input int mode, input bit poke,
                             input bit exp_err, input int exp_end);
        logic [31:0] expq[$];
        logic [31:0] xs;
        logic [31:0] held;
        int got, cyc, first_v, last_hs, phase;
        bit seen_done, stall, bad_err, rdy;
        bit pat [6] = '{1, 0, 0, 1, 0, 1};
        xs = '0;
        expq = {};
        if (!exp_err) begin
            for (int k = 0; k < len; k++) begin
                expq.push_back(rom_mem[(sa + k) % N]);
                xs ^= rom_mem[(sa + k) % N];
            end
        end
        @(negedge clk);
        start = 1'b1;
        start_addr = AW'(sa);
        length = LW'(len);
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, " err"}, 32'(err), 32'(exp_err));
        if (exp_err || len == 0) begin
            chk({name, " idle busy"}, 32'(busy), 32'd0);
            chk({name, " idle done"}, 32'(done), 32'(!exp_err));
            chk({name, " idle valid"}, 32'(out_valid), 32'd0);
            @(negedge clk);
            chk({name, " pulse done"}, 32'(done), 32'd0);
            chk({name, " pulse err"}, 32'(err), 32'd0);
            return;
        end
        chk({name, " busy"}, 32'(busy), 32'd1);
        got = 0; first_v = -1; last_hs = -1; phase = 0;
        seen_done = 0; stall = 0; bad_err = 0; held = '0;
        for (cyc = 1; cyc < 1000; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (err) bad_err = 1;
            if (stall) begin
                chk({name, " stall valid"}, 32'(out_valid), 32'd1);
                chk({name, " stall data"}, out_data, held);
            end
            if (done) begin
                seen_done = 1;
                break;
            end
            start = poke && (cyc == 3);
            if (start) begin
                start_addr = AW'(50);
                length = LW'(3);
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = pat[phase % 6];
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            phase++;
            out_ready = rdy;
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (rdy) begin
                    if (expq.size() == 0) begin
                        chk({name, " extra word"}, out_data, 32'hDEAD_BEEF);
                    end else begin
                        chk({name, " word"}, out_data, expq.pop_front());
                    end
                    got++;
                    last_hs = cyc;
                end
            end
            stall = out_valid && !rdy;
            held = out_data;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk({name, " done seen"}, 32'(seen_done), 32'd1);
        chk({name, " count"}, 32'(got), 32'(len));
        chk({name, " first valid"}, 32'(first_v), 32'd2);
        chk({name, " done lat"}, 32'(cyc), 32'(last_hs + 1));
        if (mode == 0) chk({name, " stream"}, 32'(cyc), 32'(len + 2));
        chk({name, " no err"}, 32'(bad_err), 32'd0);
        chk({name, " end busy"}, 32'(busy), 32'd0);
        chk({name, " end valid"}, 32'(out_valid), 32'd0);
        chk({name, " end addr"}, 32'(rom_addr), 32'(exp_end));
`ifdef ROM_STREAM_CHECKSUM_EN
        chk({name, " checksum"}, checksum, xs);
`endif
        @(negedge clk);
        chk({name, " done pulse"}, 32'(done), 32'd0);
`ifdef ROM_STREAM_CHECKSUM_EN
        chk({name, " checksum hold"}, checksum, xs);
`endif
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit any_done;
        for (int i = 0; i < N; i++) rom_mem[i] = 32'hA000_0000 + 32'(i);
        rom_mem[40] = 32'h1;
        rom_mem[41] = 32'h2;
        rom_mem[42] = 32'h4;
        rom_mem[43] = 32'h8;

        vecs[0] = '{3, 4, 0, 0, 0, 7};
        vecs[1] = '{62, 4, 0, 0, 0, 2};
        vecs[2] = '{3, 4, 1, 0, 0, 7};
        vecs[3] = '{0, 0, 0, 0, 0, 0};
        vecs[4] = '{0, 65, 0, 0, 1, 0};
        vecs[5] = '{40, 4, 0, 1, 0, 44};
        vecs[6] = '{10, 64, 0, 0, 0, 10};
        vecs[7] = '{63, 1, 1, 0, 0, 0};
        vecs[8] = '{5, 127, 0, 0, 1, 0};
        vecs[9] = '{20, 9, 1, 1, 0, 29};

        rst_n = 1'b0;
        start = 1'b0;
        start_addr = '0;
        length = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst valid", 32'(out_valid), 32'd0);
        chk("rst addr", 32'(rom_addr), 32'd0);
        chk("rst data", out_data, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_burst($sformatf("vec%0d", i), vecs[i].sa, vecs[i].len,
                      vecs[i].mode, vecs[i].poke, vecs[i].exp_err,
                      vecs[i].exp_end);
        end

        // reset while the second word of a length-8 burst is presented
        @(negedge clk);
        start = 1'b1;
        start_addr = AW'(10);
        length = LW'(8);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid w1", out_data, rom_mem[10]);
        @(negedge clk);
        chk("mid w2", out_data, rom_mem[11]);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid valid", 32'(out_valid), 32'd0);
        chk("mid busy", 32'(busy), 32'd0);
        chk("mid addr", 32'(rom_addr), 32'd0);
        chk("mid done", 32'(done), 32'd0);
        any_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || out_valid || busy) any_done = 1;
        end
        chk("mid quiet", 32'(any_done), 32'd0);
        run_burst("post rst", 3, 4, 0, 0, 0, 7);

        for (int r = 0; r < 20; r++) begin
            int sa, len;
            sa = $urandom_range(0, N - 1);
            len = $urandom_range(0, 70);
            run_burst($sformatf("rnd%0d", r), sa, len, 2, r[0],
                      len > N, (sa + len) % N);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
